// File: rtl/xge_arb_pkg.sv
// Shared types and sizes for the two-requester XGE TX arbiter.
package xge_arb_pkg;

  localparam int unsigned NUM_RQ    = 2;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned MOD_W     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2
  } arb_state_e;

  // One beat as carried on a requester or the MAC enqueue port.
  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [MOD_W-1:0]  mod;
    logic [DATA_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/xge_tx_arbiter_if.sv
// Requester streams plus MAC enqueue port of the XGE TX arbiter.
interface xge_tx_arbiter_if
  import xge_arb_pkg::*;
();

  logic              rq0_val;
  logic              rq0_sop;
  logic              rq0_eop;
  logic [MOD_W-1:0]  rq0_mod;
  logic [DATA_W-1:0] rq0_data;
  logic              rq0_rdy;

  logic              rq1_val;
  logic              rq1_sop;
  logic              rq1_eop;
  logic [MOD_W-1:0]  rq1_mod;
  logic [DATA_W-1:0] rq1_data;
  logic              rq1_rdy;

  logic              pkt_tx_full;
  logic              pkt_tx_val;
  logic              pkt_tx_sop;
  logic              pkt_tx_eop;
  logic [MOD_W-1:0]  pkt_tx_mod;
  logic [DATA_W-1:0] pkt_tx_data;

  // Upstream side: requesters and MAC FIFO model.
  modport master (
    output rq0_val, rq0_sop, rq0_eop, rq0_mod, rq0_data,
    input  rq0_rdy,
    output rq1_val, rq1_sop, rq1_eop, rq1_mod, rq1_data,
    input  rq1_rdy,
    output pkt_tx_full,
    input  pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data
  );

  // Arbiter side.
  modport slave (
    input  rq0_val, rq0_sop, rq0_eop, rq0_mod, rq0_data,
    output rq0_rdy,
    input  rq1_val, rq1_sop, rq1_eop, rq1_mod, rq1_data,
    output rq1_rdy,
    input  pkt_tx_full,
    output pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data
  );

endinterface

// File: rtl/xge_rr_arb.sv
// 2-way round-robin tie-break; pointer remembers the last granted port.
module xge_rr_arb
  import xge_arb_pkg::*;
(
  input  logic              clk_156m25,
  input  logic              reset_156m25_n,
  input  logic [NUM_RQ-1:0] req,
  input  logic              update,
  output logic [NUM_RQ-1:0] grant
);

  // 1: port 1 was granted last, so port 0 wins the next tie.
  logic last_q;

  // Grant the single requester, or on a tie the port not granted last.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end
  end

  // Pointer moves when the grant is taken.
  always_ff @(posedge clk_156m25) begin
    if (!reset_156m25_n) begin
      last_q <= 1'b1;
    end else if (update) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/xge_tx_arbiter.sv
// Packet-granular arbiter sharing the MAC TX enqueue port between two requesters.
module xge_tx_arbiter
  import xge_arb_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk_156m25,
  input  logic             reset_156m25_n,
  xge_tx_arbiter_if.slave  bus,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic [CNT_W-1:0] drop_cnt
);

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic [NUM_RQ-1:0] cand;
  logic [NUM_RQ-1:0] grant;
  logic              arb_upd;
  logic              rdy0;
  logic              rdy1;
  logic              fwd0;
  logic              fwd1;
  logic              drop0;
  logic              drop1;
  beat_t             beat0;
  beat_t             beat1;
  beat_t             fwd_beat;
  logic [CNT_W:0]    drop_sum;
  logic [CNT_W-1:0]  drop_nxt;

  // A port competes for the link only with a start-of-packet beat.
  assign cand = {bus.rq1_val & bus.rq1_sop, bus.rq0_val & bus.rq0_sop};

  assign beat0 = '{sop: bus.rq0_sop, eop: bus.rq0_eop, mod: bus.rq0_mod, data: bus.rq0_data};
  assign beat1 = '{sop: bus.rq1_sop, eop: bus.rq1_eop, mod: bus.rq1_mod, data: bus.rq1_data};

  xge_rr_arb u_rr_arb (
    .clk_156m25     (clk_156m25),
    .reset_156m25_n (reset_156m25_n),
    .req            (cand),
    .update         (arb_upd),
    .grant          (grant)
  );

  // State register.
  always_ff @(posedge clk_156m25) begin
    if (!reset_156m25_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, ready and accept strobes.
  always_comb begin
    state_d = state_q;
    arb_upd = 1'b0;
    rdy0    = 1'b0;
    rdy1    = 1'b0;
    fwd0    = 1'b0;
    fwd1    = 1'b0;
    drop0   = 1'b0;
    drop1   = 1'b0;
    case (state_q)
      IDLE: begin
        // Mid-packet beats with no owner are swallowed and counted.
        drop0   = bus.rq0_val & ~bus.rq0_sop;
        drop1   = bus.rq1_val & ~bus.rq1_sop;
        rdy0    = drop0;
        rdy1    = drop1;
        arb_upd = |cand;
        if (grant[0]) begin
          state_d = SEND0;
        end else if (grant[1]) begin
          state_d = SEND1;
        end
      end
      SEND0: begin
        rdy0 = ~bus.pkt_tx_full;
        fwd0 = bus.rq0_val & ~bus.pkt_tx_full;
        if (fwd0 && bus.rq0_eop) begin
          state_d = IDLE;
        end
      end
      SEND1: begin
        rdy1 = ~bus.pkt_tx_full;
        fwd1 = bus.rq1_val & ~bus.pkt_tx_full;
        if (fwd1 && bus.rq1_eop) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Nothing is accepted while reset is held.
  assign bus.rq0_rdy = reset_156m25_n & rdy0;
  assign bus.rq1_rdy = reset_156m25_n & rdy1;

  assign fwd_beat = fwd1 ? beat1 : beat0;

  // Saturating drop count; both ports may drop in the same cycle.
  assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(drop0) + (CNT_W+1)'(drop1);
  assign drop_nxt = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];

  // MAC output register and counters.
  always_ff @(posedge clk_156m25) begin
    if (!reset_156m25_n) begin
      bus.pkt_tx_val  <= 1'b0;
      bus.pkt_tx_sop  <= 1'b0;
      bus.pkt_tx_eop  <= 1'b0;
      bus.pkt_tx_mod  <= '0;
      bus.pkt_tx_data <= '0;
      pkt_cnt0        <= '0;
      pkt_cnt1        <= '0;
      drop_cnt        <= '0;
    end else begin
      bus.pkt_tx_val <= fwd0 | fwd1;
      if (fwd0 || fwd1) begin
        bus.pkt_tx_sop  <= fwd_beat.sop;
        bus.pkt_tx_eop  <= fwd_beat.eop;
        bus.pkt_tx_mod  <= fwd_beat.mod;
        bus.pkt_tx_data <= fwd_beat.data;
      end
      if (fwd0 && bus.rq0_eop) begin
        pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
      end
      if (fwd1 && bus.rq1_eop) begin
        pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
      end
      drop_cnt <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_xge_tx_arbiter.sv
// Directed bench for xge_tx_arbiter with hand-computed expected beats and counters.
module tb_xge_tx_arbiter;

  localparam int unsigned CNT_W = 16;

  logic             clk_156m25;
  logic             reset_156m25_n;
  logic [CNT_W-1:0] pkt_cnt0;
  logic [CNT_W-1:0] pkt_cnt1;
  logic [CNT_W-1:0] drop_cnt;
  int               n_chk;
  int               n_err;

  xge_tx_arbiter_if bus ();

  xge_tx_arbiter #(.CNT_W(CNT_W)) dut (
    .clk_156m25     (clk_156m25),
    .reset_156m25_n (reset_156m25_n),
    .bus            (bus),
    .pkt_cnt0       (pkt_cnt0),
    .pkt_cnt1       (pkt_cnt1),
    .drop_cnt       (drop_cnt)
  );

  initial begin
    clk_156m25 = 1'b0;
    forever #5 clk_156m25 = ~clk_156m25;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_156m25);
    #1;
  endtask

  task automatic drv0(input logic v, input logic s, input logic e, input logic [2:0] m,
                      input logic [63:0] d);
    bus.rq0_val  = v;
    bus.rq0_sop  = s;
    bus.rq0_eop  = e;
    bus.rq0_mod  = m;
    bus.rq0_data = d;
  endtask

  task automatic drv1(input logic v, input logic s, input logic e, input logic [2:0] m,
                      input logic [63:0] d);
    bus.rq1_val  = v;
    bus.rq1_sop  = s;
    bus.rq1_eop  = e;
    bus.rq1_mod  = m;
    bus.rq1_data = d;
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    #1;
    chk({tag, ".rdy0"}, 64'(bus.rq0_rdy), 64'(r0));
    chk({tag, ".rdy1"}, 64'(bus.rq1_rdy), 64'(r1));
  endtask

  task automatic chk_out(input string tag, input logic v, input logic s, input logic e,
                         input logic [2:0] m, input logic [63:0] d);
    chk({tag, ".val"}, 64'(bus.pkt_tx_val), 64'(v));
    if (v) begin
      chk({tag, ".sop"},  64'(bus.pkt_tx_sop), 64'(s));
      chk({tag, ".eop"},  64'(bus.pkt_tx_eop), 64'(e));
      chk({tag, ".mod"},  64'(bus.pkt_tx_mod), 64'(m));
      chk({tag, ".data"}, bus.pkt_tx_data, d);
    end
  endtask

  task automatic chk_cnt(input string tag, input int c0, input int c1, input int dr);
    chk({tag, ".cnt0"}, 64'(pkt_cnt0), 64'(c0));
    chk({tag, ".cnt1"}, 64'(pkt_cnt1), 64'(c1));
    chk({tag, ".drop"}, 64'(drop_cnt), 64'(dr));
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, ".val"},  64'(bus.pkt_tx_val), 64'd0);
    chk({tag, ".sop"},  64'(bus.pkt_tx_sop), 64'd0);
    chk({tag, ".eop"},  64'(bus.pkt_tx_eop), 64'd0);
    chk({tag, ".mod"},  64'(bus.pkt_tx_mod), 64'd0);
    chk({tag, ".data"}, bus.pkt_tx_data, 64'd0);
    chk_cnt(tag, 0, 0, 0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset_156m25_n = 1'b0;
    bus.pkt_tx_full = 1'b0;
    drv0(0, 0, 0, 0, 64'd0);
    drv1(0, 0, 0, 0, 64'd0);

    // Reset values; a stray beat during reset must not see rdy
    tick();
    drv1(1, 0, 0, 0, 64'h5a5a);
    tick();
    chk_rst("rst");
    chk_rdy("rst", 0, 0);
    drv1(0, 0, 0, 0, 64'd0);
    reset_156m25_n = 1'b1;

    // Tie after reset: rq0 first, then rq1, then next tie back to rq0
    drv0(1, 1, 0, 0, 64'hA0);
    drv1(1, 1, 0, 0, 64'hB0);
    chk_rdy("tie.idle", 0, 0);
    tick();
    chk("tie.gap0", 64'(bus.pkt_tx_val), 64'd0);
    chk_rdy("tie.g0", 1, 0);
    tick();
    chk_out("tie.a0", 1, 1, 0, 3'd0, 64'hA0);
    drv0(1, 0, 1, 1, 64'hA1);
    chk_rdy("tie.a1", 1, 0);
    tick();
    chk_out("tie.a1", 1, 0, 1, 3'd1, 64'hA1);
    chk_cnt("tie.a", 1, 0, 0);
    drv0(0, 0, 0, 0, 64'd0);
    chk_rdy("tie.arb1", 0, 0);
    tick();
    chk("tie.gap1", 64'(bus.pkt_tx_val), 64'd0);
    chk_rdy("tie.g1", 0, 1);
    tick();
    chk_out("tie.b0", 1, 1, 0, 3'd0, 64'hB0);
    drv1(1, 0, 1, 2, 64'hB1);
    tick();
    chk_out("tie.b1", 1, 0, 1, 3'd2, 64'hB1);
    chk_cnt("tie.b", 1, 1, 0);
    drv0(1, 1, 1, 3, 64'hA2);
    drv1(1, 1, 1, 4, 64'hB2);
    tick();
    chk_rdy("tie2.g0", 1, 0);
    tick();
    chk_out("tie2.a2", 1, 1, 1, 3'd3, 64'hA2);
    chk_cnt("tie2.a", 2, 1, 0);
    drv0(0, 0, 0, 0, 64'd0);
    tick();
    chk("tie2.gap", 64'(bus.pkt_tx_val), 64'd0);
    chk_rdy("tie2.g1", 0, 1);
    tick();
    chk_out("tie2.b2", 1, 1, 1, 3'd4, 64'hB2);
    chk_cnt("tie2.b", 2, 2, 0);
    drv1(0, 0, 0, 0, 64'd0);

    // rq0 3-beat packet: beats appear T+2..T+4
    drv0(1, 1, 0, 0, 64'hD0);
    tick();
    chk("p3.arb", 64'(bus.pkt_tx_val), 64'd0);
    chk_rdy("p3.g0", 1, 0);
    tick();
    chk_out("p3.d0", 1, 1, 0, 3'd0, 64'hD0);
    drv0(1, 0, 0, 0, 64'hD1);
    tick();
    chk_out("p3.d1", 1, 0, 0, 3'd0, 64'hD1);
    drv0(1, 0, 1, 5, 64'hD2);
    tick();
    chk_out("p3.d2", 1, 0, 1, 3'd5, 64'hD2);
    chk_cnt("p3", 3, 2, 0);
    drv0(0, 0, 0, 0, 64'd0);
    tick();
    chk("p3.after", 64'(bus.pkt_tx_val), 64'd0);

    // Back-pressure for 4 cycles during beat 2 of a 4-beat packet
    drv0(1, 1, 0, 0, 64'hE0);
    tick();
    chk_rdy("full.g0", 1, 0);
    tick();
    chk_out("full.e0", 1, 1, 0, 3'd0, 64'hE0);
    drv0(1, 0, 0, 0, 64'hE1);
    bus.pkt_tx_full = 1'b1;
    chk_rdy("full.c0", 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full.gap", 64'(bus.pkt_tx_val), 64'd0);
      chk_rdy("full.stall", 0, 0);
    end
    tick();
    chk("full.gap4", 64'(bus.pkt_tx_val), 64'd0);
    bus.pkt_tx_full = 1'b0;
    chk_rdy("full.resume", 1, 0);
    tick();
    chk_out("full.e1", 1, 0, 0, 3'd0, 64'hE1);
    drv0(1, 0, 0, 0, 64'hE2);
    tick();
    chk_out("full.e2", 1, 0, 0, 3'd0, 64'hE2);
    drv0(1, 0, 1, 0, 64'hE3);
    tick();
    chk_out("full.e3", 1, 0, 1, 3'd0, 64'hE3);
    chk_cnt("full", 4, 2, 0);
    drv0(0, 0, 0, 0, 64'd0);

    // Orphan beats on rq1 while idle are dropped
    tick();
    chk("drop.v0", 64'(bus.pkt_tx_val), 64'd0);
    drv1(1, 0, 0, 0, 64'hC0);
    chk_rdy("drop.r0", 0, 1);
    tick();
    chk("drop.v1", 64'(bus.pkt_tx_val), 64'd0);
    chk_cnt("drop.1", 4, 2, 1);
    drv1(1, 0, 1, 7, 64'hC1);
    chk_rdy("drop.r1", 0, 1);
    tick();
    chk("drop.v2", 64'(bus.pkt_tx_val), 64'd0);
    chk_cnt("drop.2", 4, 2, 2);
    drv1(0, 0, 0, 0, 64'd0);
    tick();
    chk("drop.v3", 64'(bus.pkt_tx_val), 64'd0);
    chk_cnt("drop.3", 4, 2, 2);

    // Reset after beat 1 of a 3-beat packet; leftovers count as drops
    drv0(1, 1, 0, 0, 64'hF0);
    tick();
    chk_rdy("mrst.g0", 1, 0);
    tick();
    chk_out("mrst.f0", 1, 1, 0, 3'd0, 64'hF0);
    drv0(1, 0, 0, 0, 64'hF1);
    reset_156m25_n = 1'b0;
    chk_rdy("mrst.hold", 0, 0);
    tick();
    chk_rst("mrst");
    reset_156m25_n = 1'b1;
    chk_rdy("mrst.f1", 1, 0);
    tick();
    chk("mrst.v1", 64'(bus.pkt_tx_val), 64'd0);
    chk_cnt("mrst.d1", 0, 0, 1);
    drv0(1, 0, 1, 2, 64'hF2);
    chk_rdy("mrst.f2", 1, 0);
    tick();
    chk("mrst.v2", 64'(bus.pkt_tx_val), 64'd0);
    chk_cnt("mrst.d2", 0, 0, 2);
    drv0(1, 1, 1, 1, 64'hF3);
    chk_rdy("mrst.new", 0, 0);
    tick();
    chk_rdy("mrst.g1", 1, 0);
    tick();
    chk_out("mrst.f3", 1, 1, 1, 3'd1, 64'hF3);
    chk_cnt("mrst.p", 1, 0, 2);
    drv0(0, 0, 0, 0, 64'd0);

    // Single-beat packets on both ports after a fresh reset
    reset_156m25_n = 1'b0;
    tick();
    reset_156m25_n = 1'b1;
    drv0(1, 1, 1, 0, 64'h50);
    drv1(1, 1, 1, 6, 64'h51);
    tick();
    chk_rdy("one.g0", 1, 0);
    tick();
    chk_out("one.s0", 1, 1, 1, 3'd0, 64'h50);
    drv0(0, 0, 0, 0, 64'd0);
    tick();
    chk("one.gap", 64'(bus.pkt_tx_val), 64'd0);
    chk_rdy("one.g1", 0, 1);
    tick();
    chk_out("one.s1", 1, 1, 1, 3'd6, 64'h51);
    chk_cnt("one", 1, 1, 0);
    drv1(0, 0, 0, 0, 64'd0);
    tick();
    chk("one.after", 64'(bus.pkt_tx_val), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
